msk_tweakey_feed: RTL and testbench

// - Masked Clyde-128 tweakey generator. Holds the d-share key and the public tweak.
// - Emits one masked tweakey per Clyde step to the downstream parallel share-XOR stage (count=128), which adds it to the state.
// - Emits NSTEPS+1 tweakeys per block: the initial addition plus one after each step.

---
 rtl/msk_clyde_pkg.sv | 40 ++++
 rtl/msk_share_add0.sv | 30 +++
 rtl/msk_tweakey_feed.sv | 193 +++++++++++++++++++
 tb/tb_msk_tweakey_feed.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_clyde_pkg.sv
// -----------------------------------------------------------------------------
// msk_clyde_pkg
// Shared definitions for the masked Clyde-128 datapath blocks.
//   CLYDE_W      : state / tweakey width in bits
//   HALF_W       : width of one tweak half (t0 or t1)
//   tk_state_e   : tweakey feeder FSM states
//   tk_phase_sel : builds the public tweak word T for phase p (0,1,2)
// -----------------------------------------------------------------------------
package msk_clyde_pkg;

    localparam int CLYDE_W = 128;
    localparam int HALF_W  = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tk_state_e;

    // Tweak schedule. Result is written as {MSB half, LSB half}.
    //   p=0 : t1        || t0
    //   p=1 : t0        || t0^t1
    //   p=2 : t0^t1     || t1
    function automatic logic [CLYDE_W-1:0] tk_phase_sel(
        input logic [CLYDE_W-1:0] t,
        input logic [1:0]         p
    );
        logic [HALF_W-1:0] t0;
        logic [HALF_W-1:0] t1;
        logic [CLYDE_W-1:0] r;
        t0 = t[HALF_W-1:0];
        t1 = t[CLYDE_W-1:HALF_W];
        case (p)
            2'd1:    r = {t0, t0 ^ t1};
            2'd2:    r = {t0 ^ t1, t1};
            default: r = {t1, t0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/msk_share_add0.sv
// -----------------------------------------------------------------------------
// msk_share_add0
// Adds a public CLYDE_W-bit value to share 0 of a d-share bus. Shares 1..d-1
// pass through untouched, so shares are never combined. Also used for the
// round-constant addition elsewhere in the datapath.
// Parameters:
//   d          : number of shares
// Ports:
//   shares_in  : in  CLYDE_W*d  shares, bits [i*d +: d] hold the shares of bit i
//   pub_in     : in  CLYDE_W    public value to add
//   shares_out : out CLYDE_W*d  shares_in with pub_in XORed into share 0
// -----------------------------------------------------------------------------
module msk_share_add0
    import msk_clyde_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [CLYDE_W*d-1:0] shares_in,
    input  logic [CLYDE_W-1:0]   pub_in,
    output logic [CLYDE_W*d-1:0] shares_out
);

    always_comb begin
        shares_out = shares_in;
        for (int i = 0; i < CLYDE_W; i++) begin
            shares_out[i*d] = shares_in[i*d] ^ pub_in[i];
        end
    end

endmodule

// File: rtl/msk_tweakey_feed.sv
// -----------------------------------------------------------------------------
// msk_tweakey_feed
// Masked Clyde-128 tweakey generator. Holds the d-share key and the public
// tweak, and emits NSTEPS+1 masked tweakeys per block (initial addition plus
// one after each step) to the downstream share-XOR stage.
//
// Optional feature: define MSK_TK_REFRESH_EN to refresh the key sharing with
// fresh randomness on every tweakey handshake (adds the rnd port).
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
//   Load side : ld_valid/ld_ready, ld_ready high only in IDLE; ld_valid in RUN
//               is ignored and upstream must hold it until ld_ready.
//   Output    : tk_valid/tk_ready, tk_out and tk_idx hold while stalled.
//
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   key_in     : in  128*d     masked key, bits [i*d +: d] = shares of bit i
//   tweak_in   : in  128       public tweak, t0=[63:0], t1=[127:64]
//   ld_valid   : in            key_in/tweak_in valid
//   ld_ready   : out           load accepted (IDLE)
//   tk_out     : out 128*d     masked tweakey, same layout as key_in
//   tk_valid   : out           tk_out valid
//   tk_ready   : in            downstream consumes tk_out
//   tk_idx     : out 3         tweakey index s (0..NSTEPS)
//   done       : out           one-cycle pulse after the last tweakey is consumed
//   rnd        : in  128*(d-1) fresh randomness (MSK_TK_REFRESH_EN only)
//   state_dbg  : out           current FSM state, for observation
// -----------------------------------------------------------------------------
module msk_tweakey_feed
    import msk_clyde_pkg::*;
#(
    parameter int d      = 2,
    parameter int NSTEPS = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CLYDE_W*d-1:0]     key_in,
    input  logic [CLYDE_W-1:0]       tweak_in,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    output logic [CLYDE_W*d-1:0]     tk_out,
    output logic                     tk_valid,
    input  logic                     tk_ready,
    output logic [2:0]               tk_idx,
    output logic                     done,
`ifdef MSK_TK_REFRESH_EN
    input  logic [CLYDE_W*(d-1)-1:0] rnd,
`endif
    output tk_state_e                state_dbg
);

    tk_state_e              state_q,    state_d;
    logic [CLYDE_W*d-1:0]   key_q,      key_d;
    logic [CLYDE_W-1:0]     tweak_q,    tweak_d;
    logic [2:0]             idx_q,      idx_d;
    logic [1:0]             phase_q,    phase_d;
    logic [CLYDE_W*d-1:0]   tk_out_q,   tk_out_d;
    logic                   tk_valid_q, tk_valid_d;
    logic                   done_q,     done_d;
    logic                   ld_ready_q, ld_ready_d;

    logic                   hs;
    logic                   last_step;
    logic [1:0]             phase_nxt;
    logic [CLYDE_W*d-1:0]   key_ref;
    logic [CLYDE_W*d-1:0]   sel_key;
    logic [CLYDE_W-1:0]     sel_tweak;
    logic [1:0]             sel_phase;
    logic [CLYDE_W*d-1:0]   add_out;

    assign hs        = tk_valid_q && tk_ready;
    assign last_step = (idx_q == 3'(NSTEPS));
    assign phase_nxt = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;

    // Key sharing used after a handshake. With refresh, each share j>=1 takes
    // its own random slice and share 0 absorbs all slices, so the XOR of the
    // shares is preserved without ever recombining them.
`ifdef MSK_TK_REFRESH_EN
    always_comb begin
        key_ref = key_q;
        for (int i = 0; i < CLYDE_W; i++) begin
            for (int j = 1; j < d; j++) begin
                key_ref[i*d+j] = key_q[i*d+j] ^ rnd[(j-1)*CLYDE_W+i];
                key_ref[i*d]   = key_ref[i*d] ^ rnd[(j-1)*CLYDE_W+i];
            end
        end
    end
`else
    assign key_ref = key_q;
`endif

    // The next tweakey is precomputed from the values the registers will hold
    // next cycle, so tk_out comes straight from a flop. In IDLE that is the
    // freshly loaded key/tweak at phase 0; in RUN the (refreshed) key at the
    // next phase.
    always_comb begin
        sel_key   = key_ref;
        sel_tweak = tweak_q;
        sel_phase = phase_nxt;
        if (state_q == IDLE) begin
            sel_key   = key_in;
            sel_tweak = tweak_in;
            sel_phase = 2'd0;
        end
    end

    msk_share_add0 #(
        .d (d)
    ) u_add0 (
        .shares_in  (sel_key),
        .pub_in     (tk_phase_sel(sel_tweak, sel_phase)),
        .shares_out (add_out)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        tweak_d    = tweak_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        tk_out_d   = tk_out_q;
        tk_valid_d = tk_valid_q;
        done_d     = 1'b0;
        ld_ready_d = ld_ready_q;
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    state_d    = RUN;
                    key_d      = key_in;
                    tweak_d    = tweak_in;
                    idx_d      = 3'd0;
                    phase_d    = 2'd0;
                    tk_out_d   = add_out;
                    tk_valid_d = 1'b1;
                    ld_ready_d = 1'b0;
                end
            end
            RUN: begin
                if (hs) begin
                    key_d = key_ref;
                    if (last_step) begin
                        state_d    = IDLE;
                        idx_d      = 3'd0;
                        tk_valid_d = 1'b0;
                        done_d     = 1'b1;
                        ld_ready_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        phase_d  = phase_nxt;
                        tk_out_d = add_out;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tk_valid_d = 1'b0;
                ld_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            tweak_q    <= '0;
            idx_q      <= 3'd0;
            phase_q    <= 2'd0;
            tk_out_q   <= '0;
            tk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ld_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            tweak_q    <= tweak_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            tk_out_q   <= tk_out_d;
            tk_valid_q <= tk_valid_d;
            done_q     <= done_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    assign ld_ready  = ld_ready_q;
    assign tk_out    = tk_out_q;
    assign tk_valid  = tk_valid_q;
    assign tk_idx    = idx_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_msk_tweakey_feed.sv
// -----------------------------------------------------------------------------
// tb_msk_tweakey_feed
// Bench for msk_tweakey_feed: a d=2 instance with a scoreboard/monitor, and a
// d=3 instance for share pass-through. Define MSK_TK_REFRESH_EN for the
// refresh build.
// -----------------------------------------------------------------------------
module tb_msk_tweakey_feed;
    import msk_clyde_pkg::*;

    localparam int NS = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- d=2 DUT ----------------
    logic [255:0] key_in;
    logic [127:0] tweak_in;
    logic         ld_valid;
    logic         ld_ready;
    logic [255:0] tk_out;
    logic         tk_valid;
    logic         tk_ready;
    logic [2:0]   tk_idx;
    logic         done;
    tk_state_e    state_dbg;
`ifdef MSK_TK_REFRESH_EN
    logic [127:0] rnd;
`endif

    msk_tweakey_feed #(.d(2), .NSTEPS(NS)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .tweak_in  (tweak_in),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .tk_out    (tk_out),
        .tk_valid  (tk_valid),
        .tk_ready  (tk_ready),
        .tk_idx    (tk_idx),
        .done      (done),
`ifdef MSK_TK_REFRESH_EN
        .rnd       (rnd),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- d=3 DUT ----------------
    logic [383:0] key3;
    logic [127:0] tweak3;
    logic         ld_valid3;
    logic         ld_ready3;
    logic [383:0] tk3;
    logic         tk_valid3;
    logic         tk_ready3;
    logic [2:0]   tk_idx3;
    logic         done3;
    tk_state_e    state_dbg3;
`ifdef MSK_TK_REFRESH_EN
    logic [255:0] rnd3;
`endif

    msk_tweakey_feed #(.d(3), .NSTEPS(NS)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key3),
        .tweak_in  (tweak3),
        .ld_valid  (ld_valid3),
        .ld_ready  (ld_ready3),
        .tk_out    (tk3),
        .tk_valid  (tk_valid3),
        .tk_ready  (tk_ready3),
        .tk_idx    (tk_idx3),
        .done      (done3),
`ifdef MSK_TK_REFRESH_EN
        .rnd       (rnd3),
`endif
        .state_dbg (state_dbg3)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int ready_mode = 0;            // 0: always 1, 1: toggle, 2: random
    logic [130:0] exp_q[$];        // {tk_idx, unmasked tweakey}

    // ---------------- reference model ----------------
    // Halves h0=t0, h1=t1, h2=t0^t1; each phase rotates which pair is used.
    function automatic logic [127:0] model_t(input logic [127:0] t, input int p);
        logic [63:0] h[3];
        h[0] = t[63:0];
        h[1] = t[127:64];
        h[2] = h[0] ^ h[1];
        return {h[(4 - p) % 3], h[(3 - p) % 3]};
    endfunction

    function automatic logic [255:0] pack2(input logic [127:0] s0, input logic [127:0] s1);
        logic [255:0] r;
        for (int i = 0; i < 128; i++) begin
            r[2*i]   = s0[i];
            r[2*i+1] = s1[i];
        end
        return r;
    endfunction

    function automatic logic [127:0] share2(input logic [255:0] x, input int j);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = x[2*i+j];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [130:0] act, input logic [130:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- ready / randomness driver ----------------
    initial begin
        tk_ready = 1'b1;
`ifdef MSK_TK_REFRESH_EN
        rnd  = '0;
        rnd3 = '0;
`endif
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tk_ready = 1'b1;
                1:       tk_ready = ~tk_ready;
                default: tk_ready = 1'($urandom_range(0, 1));
            endcase
`ifdef MSK_TK_REFRESH_EN
            rnd  = rand128();
            rnd3 = {rand128(), rand128()};
`endif
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic         exp_done = 1'b0;
    logic         have_stall = 1'b0;
    logic [255:0] prev_out;
    logic [2:0]   prev_idx;
    logic         after_hs = 1'b0;
    logic [127:0] hs_share1;

    always @(negedge clk) begin
        if (rst) begin
            exp_done   = 1'b0;
            have_stall = 1'b0;
            after_hs   = 1'b0;
        end else begin
            check("done_pulse", 131'(done), 131'(exp_done));
            exp_done = 1'b0;
            if (tk_valid) begin
                if (have_stall) begin
                    check("stall_hold_out", 131'(tk_out), 131'(prev_out));
                    check("stall_hold_idx", 131'(tk_idx), 131'(prev_idx));
                end
`ifdef MSK_TK_REFRESH_EN
                if (after_hs) begin
                    checks++;
                    if (share2(tk_out, 1) === hs_share1) begin
                        errors++;
                        $display("FAIL refresh_share1 actual=%h required=not %h", share2(tk_out, 1), hs_share1);
                    end
                end
`endif
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tk actual=idx %0d required=no output", tk_idx);
                end else begin
                    check("tk_value", {tk_idx, share2(tk_out, 0) ^ share2(tk_out, 1)}, exp_q[0]);
                    if (tk_ready) begin
                        void'(exp_q.pop_front());
                        if (tk_idx == 3'(NS)) exp_done = 1'b1;
                    end
                end
                have_stall = !tk_ready;
                after_hs   = tk_ready && (tk_idx != 3'(NS));
                hs_share1  = share2(tk_out, 1);
                prev_out   = tk_out;
                prev_idx   = tk_idx;
            end else begin
                have_stall = 1'b0;
                after_hs   = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1. Returns at posedge+1 after the load edge.
    task automatic load_block(input logic [127:0] s0, input logic [127:0] s1,
                              input logic [127:0] t, input bit keep_valid);
        int n;
        key_in   = pack2(s0, s1);
        tweak_in = t;
        ld_valid = 1'b1;
        n = 0;
        while (!ld_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ld_ready) begin
            checks++;
            errors++;
            $display("FAIL ld_ready_timeout actual=0 required=1");
        end
        for (int s = 0; s <= NS; s++) exp_q.push_back({3'(s), (s0 ^ s1) ^ model_t(t, s % 3)});
        @(posedge clk);
        #1;
        if (!keep_valid) ld_valid = 1'b0;
        check("first_tk_valid", 131'(tk_valid), 131'(1));
        check("first_tk_idx", 131'(tk_idx), 131'(0));
        check("ld_ready_run", 131'(ld_ready), 131'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 200);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic random_block();
        logic [127:0] k;
        logic [127:0] m;
        k = rand128();
        m = rand128();
        load_block(k ^ m, m, rand128(), 1'b0);
        wait_done();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] ka;
        logic [127:0] ma;
        logic [127:0] kb;
        logic [127:0] mb;
        logic [127:0] tb;
        logic [127:0] k3;
        logic [127:0] t3;
        logic [127:0] u3;
        logic [127:0] sh[3];
        int n;

        key_in = '0; tweak_in = '0; ld_valid = 1'b0;
        key3 = '0; tweak3 = '0; ld_valid3 = 1'b0; tk_ready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ld_ready", 131'(ld_ready), 131'(1));
        check("rst_tk_valid", 131'(tk_valid), 131'(0));
        check("rst_tk_idx", 131'(tk_idx), 131'(0));
        check("rst_done", 131'(done), 131'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed: K=0, t1=1, t0=2, ready held high, one tweakey per cycle.
        ready_mode = 0;
        load_block('0, '0, {64'd1, 64'd2}, 1'b0);
        for (int s = 1; s <= NS; s++) begin
            @(posedge clk);
            #1;
            check("nobubble_valid", 131'(tk_valid), 131'(1));
            check("nobubble_idx", 131'(tk_idx), 131'(s));
        end
        @(posedge clk);
        #1;
        check("done_after_last", 131'(done), 131'(1));
        check("valid_after_last", 131'(tk_valid), 131'(0));
        check("ld_ready_after_last", 131'(ld_ready), 131'(1));
        @(posedge clk);
        #1;
        check("done_one_cycle", 131'(done), 131'(0));

        // Random masked keys with stalls.
        ready_mode = 1;
        repeat (3) random_block();
        ready_mode = 2;
        repeat (4) random_block();

        // Reset at s=3.
        ready_mode = 0;
        ka = rand128();
        ma = rand128();
        load_block(ka ^ ma, ma, rand128(), 1'b0);
        n = 0;
        while (tk_idx != 3'd3 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_s3", 131'(tk_idx), 131'(3));
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_tk_valid", 131'(tk_valid), 131'(0));
        check("midrst_ld_ready", 131'(ld_ready), 131'(1));
        check("midrst_tk_idx", 131'(tk_idx), 131'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        random_block();

        // ld_valid held through RUN with different data; second block waits.
        ready_mode = 1;
        ka = rand128(); ma = rand128();
        kb = rand128(); mb = rand128(); tb = rand128();
        load_block(ka ^ ma, ma, rand128(), 1'b1);
        key_in   = pack2(kb ^ mb, mb);
        tweak_in = tb;
        wait_done();
        load_block(kb ^ mb, mb, tb, 1'b0);
        wait_done();

        // d=3: shares 1 and 2 all ones, share 0 = K.
        ready_mode = 0;
        k3 = rand128();
        t3 = rand128();
        for (int i = 0; i < 128; i++) begin
            key3[3*i]   = k3[i];
            key3[3*i+1] = 1'b1;
            key3[3*i+2] = 1'b1;
        end
        tweak3    = t3;
        ld_valid3 = 1'b1;
        @(posedge clk);
        #1;
        ld_valid3 = 1'b0;
        for (int s = 0; s <= NS; s++) begin
            for (int i = 0; i < 128; i++) begin
                sh[0][i] = tk3[3*i];
                sh[1][i] = tk3[3*i+1];
                sh[2][i] = tk3[3*i+2];
            end
            u3 = sh[0] ^ sh[1] ^ sh[2];
            check("d3_valid", 131'(tk_valid3), 131'(1));
            check("d3_idx", 131'(tk_idx3), 131'(s));
            check("d3_unmasked", 131'(u3), 131'(k3 ^ model_t(t3, s % 3)));
`ifndef MSK_TK_REFRESH_EN
            check("d3_share0", 131'(sh[0]), 131'(k3 ^ model_t(t3, s % 3)));
            check("d3_share1", 131'(sh[1]), 131'({128{1'b1}}));
            check("d3_share2", 131'(sh[2]), 131'({128{1'b1}}));
`endif
            @(posedge clk);
            #1;
        end
        check("d3_done", 131'(done3), 131'(1));

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 131'(exp_q.size()), 131'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
